// File: rtl/mem_align_unit_if.sv
// Bus bundle for mem_align_unit: MEM-stage request/response and word-memory handshake.
// slave  = the alignment unit's view, master = the pipeline/memory side driving it.
interface mem_align_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              misalign;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, misalign, stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, misalign, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_align_unit.sv
// Byte-to-word memory adapter for the MEM stage: lane extraction with sign/zero
// extension on loads, read-modify-write merging on sub-word stores.
// Optional macro MEM_ALIGN_MISALIGN_TRAP_EN: misaligned half/word accesses are
// trapped (misalign pulse, no memory access) instead of being forced aligned.
//
// state  | meaning
// IDLE   | ready for a new request
// RD     | memory read outstanding (load, or first half of a sub-word store)
// WR     | memory write outstanding
// RESP   | one-cycle completion pulse
module mem_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_align_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              misalign_q;

    logic [1:0]        acc_off;
    logic              trap_hit;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;
    logic [31:0]       merge_w;

    // Lane offset actually used: halves and words are forced onto their natural boundary.
    always_comb begin
        acc_off = bus.req_addr[1:0];
        if (bus.req_size[1]) begin
            acc_off = 2'b00;
        end else if (bus.req_size[0]) begin
            acc_off = {bus.req_addr[1], 1'b0};
        end
    end

`ifdef MEM_ALIGN_MISALIGN_TRAP_EN
    assign trap_hit = bus.req_size[1] ? (bus.req_addr[1:0] != 2'b00)
                                      : (bus.req_size[0] & bus.req_addr[0]);
`else
    assign trap_hit = 1'b0;
`endif

    // Load lane extraction/extension and sub-word store merge from the returned memory word.
    always_comb begin
        lane_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
        lane_h = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        if (size_q[1]) begin
            load_ext = bus.mem_rdata;
        end else if (size_q[0]) begin
            load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
        end else begin
            load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
        end
        merge_w = bus.mem_rdata;
        if (size_q[0]) begin
            merge_w[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merge_w[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Access sequencer: latch request, run the memory handshake(s), pulse the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q         <= bus.req_we;
                        size_q       <= bus.req_size;
                        signed_q     <= bus.req_signed;
                        off_q        <= acc_off;
                        wdata_q      <= bus.req_wdata[15:0];
                        mem_addr_q   <= bus.req_addr[ADDR_W-1:2];
                        resp_rdata_q <= '0;
                        if (trap_hit) begin
                            misalign_q <= 1'b1;
                            state_q    <= S_RESP;
                        end else if (bus.req_we && bus.req_size[1]) begin
                            mem_wdata_q <= bus.req_wdata;
                            state_q     <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (bus.mem_ack) begin
                        if (we_q) begin
                            mem_wdata_q <= merge_w;
                            state_q     <= S_WR;
                        end else begin
                            resp_rdata_q <= load_ext;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_WR: begin
                    if (bus.mem_ack) begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    misalign_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.stall      = (state_q != S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.misalign   = misalign_q;
    assign bus.mem_req    = (state_q == S_RD) || (state_q == S_WR);
    assign bus.mem_we     = (state_q == S_WR);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit: directed cases plus randomized accesses
// against a byte-lane reference model and a behavioural word memory with variable ack delay.
module tb_mem_align_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_align_unit_if #(.ADDR_W(32)) bif ();
    mem_align_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          ntx;
        int          acc_n;
        int          tx_base;
        logic [29:0] waddr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [int];
    logic [31:0] model_mem [int];
    int          n_checks = 0;
    int          n_errors = 0;
    int          neg_cnt = 0;
    int          tx_cnt = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [29:0] last_addr = '0;
    logic [29:0] s_addr;
    logic        s_we;
    logic [31:0] s_wd;
    logic        mon_en = 1'b1;
    logic        late_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(int wa);
        return 32'(wa) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] mem_get(int wa);
        return mem.exists(wa) ? mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] model_get(int wa);
        return model_mem.exists(wa) ? model_mem[wa] : init_word(wa);
    endfunction

    // Reference: byte-lane arithmetic over a word array.
    function automatic exp_t model(logic we, logic [1:0] size, logic sgn,
                                   logic [31:0] addr, logic [31:0] wd);
        exp_t        e;
        int          nb;
        int          off;
        int          wa;
        logic [31:0] w;
        logic [31:0] mask;
        nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        wa      = int'(addr >> 2);
        e.rdata = '0;
        e.mis   = 1'b0;
        e.ntx   = 0;
        e.acc_n = 0;
        e.tx_base = 0;
        e.waddr = addr[31:2];
`ifdef MEM_ALIGN_MISALIGN_TRAP_EN
        if ((addr % nb) != 0) begin
            e.mis = 1'b1;
            return e;
        end
`endif
        off  = int'(addr[1:0]) - int'(addr % nb);
        w    = model_get(wa);
        mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
        if (!we) begin
            e.ntx   = 1;
            e.rdata = (w >> (8 * off)) & mask;
            if (sgn && nb < 4 && e.rdata[8 * nb - 1]) e.rdata = e.rdata | ~mask;
        end else if (nb == 4) begin
            e.ntx = 1;
            model_mem[wa] = wd;
        end else begin
            e.ntx = 2;
            model_mem[wa] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end
        return e;
    endfunction

    // Word memory: acks after ack_delay wait cycles, checks request stability.
    always @(negedge clk) begin
        bif.mem_ack = 1'b0;
        if (rst) begin
            wait_cnt = 0;
        end else if (late_ack) begin
            bif.mem_ack = 1'b1;
        end else if (bif.mem_req) begin
            if (wait_cnt == 0) begin
                s_addr = bif.mem_addr;
                s_we   = bif.mem_we;
                s_wd   = bif.mem_wdata;
            end
            if (wait_cnt >= ack_delay) begin
                chk("mem_addr_stable", 64'(bif.mem_addr), 64'(s_addr));
                chk("mem_we_stable", 64'(bif.mem_we), 64'(s_we));
                if (s_we) chk("mem_wdata_stable", 64'(bif.mem_wdata), 64'(s_wd));
                last_addr     = bif.mem_addr;
                bif.mem_rdata = mem_get(int'(bif.mem_addr));
                if (bif.mem_we) mem[int'(bif.mem_addr)] = bif.mem_wdata;
                tx_cnt++;
                wait_cnt    = 0;
                bif.mem_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        logic busy;
        neg_cnt++;
        if (mon_en && !rst) begin
            busy = (sb.size() != 0) && (neg_cnt >= sb[0].acc_n);
            chk("stall", 64'(bif.stall), 64'(busy));
            if (!bif.resp_valid) chk("misalign_idle", 64'(bif.misalign), 64'(0));
            if (bif.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", 64'(bif.resp_rdata), 64'(e.rdata));
                    chk("misalign", 64'(bif.misalign), 64'(e.mis));
                    chk("latency", 64'(neg_cnt - e.acc_n), 64'(e.ntx * (1 + ack_delay)));
                    chk("mem_txns", 64'(tx_cnt - e.tx_base), 64'(e.ntx));
                    if (e.ntx > 0) chk("mem_addr", 64'(last_addr), 64'(e.waddr));
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int delay);
        exp_t e;
        @(negedge clk);
        #1;
        ack_delay = delay;
        e = model(we, size, sgn, addr, wd);
        e.acc_n   = neg_cnt + 1;
        e.tx_base = tx_cnt;
        sb.push_back(e);
        bif.req_we     = we;
        bif.req_size   = size;
        bif.req_signed = sgn;
        bif.req_addr   = addr;
        bif.req_wdata  = wd;
        bif.req_valid  = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic preload(input int wa, input logic [31:0] v);
        mem[wa]       = v;
        model_mem[wa] = v;
    endtask

    initial begin
        rst            = 1'b1;
        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_size   = 2'b00;
        bif.req_signed = 1'b0;
        bif.req_addr   = '0;
        bif.req_wdata  = '0;
        bif.mem_ack    = 1'b0;
        bif.mem_rdata  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bif.req_ready), 64'(1));
        chk("rst_stall", 64'(bif.stall), 64'(0));
        chk("rst_resp_valid", 64'(bif.resp_valid), 64'(0));
        chk("rst_resp_rdata", 64'(bif.resp_rdata), 64'(0));
        chk("rst_misalign", 64'(bif.misalign), 64'(0));
        chk("rst_mem_req", 64'(bif.mem_req), 64'(0));
        chk("rst_mem_we", 64'(bif.mem_we), 64'(0));
        chk("rst_mem_addr", 64'(bif.mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(bif.mem_wdata), 64'(0));
        rst = 1'b0;

        preload(32'h40, 32'h80FF_1234);
        preload(32'h08, 32'h1122_3344);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, 0);
        chk("half_store_word", 64'(mem_get(8)), 64'(32'hBEEF_3344));
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 3);
        issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
        issue(1'b0, 2'd1, 1'b1, 32'h23, 32'h0, 1);
        issue(1'b1, 2'd3, 1'b0, 32'h31, 32'hCAFE_F00D, 0);

        // Reset in the middle of a word store with memory still waiting.
        @(negedge clk);
        #1;
        mon_en         = 1'b0;
        ack_delay      = 10;
        bif.req_we     = 1'b1;
        bif.req_size   = 2'd2;
        bif.req_addr   = 32'h20;
        bif.req_wdata  = 32'h5555_AAAA;
        bif.req_valid  = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(negedge clk);
        chk("wr_mem_req_before_rst", 64'(bif.mem_req), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("midrst_mem_req", 64'(bif.mem_req), 64'(0));
        chk("midrst_resp_valid", 64'(bif.resp_valid), 64'(0));
        chk("midrst_stall", 64'(bif.stall), 64'(0));
        chk("midrst_req_ready", 64'(bif.req_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        #1 late_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("late_ack_resp_valid", 64'(bif.resp_valid), 64'(0));
            chk("late_ack_mem_req", 64'(bif.mem_req), 64'(0));
        end
        mon_en = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h40C, 32'h0, 0);
        chk("abandoned_store_word", 64'(mem_get(8)), 64'(32'hBEEF_3344));

        for (int n = 0; n < 150; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 3)));
        end

        foreach (model_mem[k]) chk("final_mem_model", 64'(mem_get(k)), 64'(model_mem[k]));
        foreach (mem[k]) chk("final_mem_dut", 64'(mem[k]), 64'(model_get(k)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Byte-to-word memory access adapter for the MEM stage of the pipelined MIPS core. Takes byte addresses from the ALU and strips the two low bits into a word address for the word-organised data memory. Performs byte/halfword lane extraction with sign/zero extension on loads, and read-modify-write merging on sub-word stores. Uses a req/ack handshake toward memory and stalls the pipeline while busy.

## Interface
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM-stage access request
- req_ready  out  1  unit idle, request accepted this cycle if req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- misalign  out  1  one-cycle pulse with resp_valid on a trapped access
- stall  out  1  = !req_ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address = req_addr[ADDR_W-1:2]
- mem_wdata  out  32  full write word
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  32  memory read word

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; half at bits [16·addr[1]+15 : 16·addr[1]].
- States: IDLE, RD, WR, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid, latch the request, then:
  - load → RD
  - word store → WR, mem_wdata = req_wdata
  - sub-word store → RD
  - trapped misalign → RESP
- RD: mem_req=1, mem_we=0.
  - On mem_ack, load: extract lane, extend per req_signed, register to resp_rdata → RESP.
  - On mem_ack, sub-word store: merge req_wdata low byte/half into mem_rdata at the lane, register to mem_wdata → WR.
- WR: mem_req=1, mem_we=1. On mem_ack → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. New request is acceptable the next cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- Reset values: state IDLE, req_ready 1, stall 0, resp_valid 0, resp_rdata 0, misalign 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset mid-operation: outputs take reset values immediately and mem_req drops. The memory side must tolerate an abandoned request. Any mem_ack arriving after reset is ignored.
- mem_ack while in IDLE or RESP: ignored.

## Timing
- Request accepted at edge 0.
- mem_req rises after edge 0. With mem_ack returned in the first request cycle:
  - load: resp_valid in the cycle after edge 1 (2-cycle latency)
  - word store: 2-cycle latency
  - sub-word store: 3-cycle latency (RD, WR, RESP)
- Each memory wait cycle adds one cycle.
- Trapped misalign: resp_valid and misalign in the cycle after acceptance; no memory access.
- stall is high from the cycle after acceptance through the RESP cycle.

## Configuration
- MEM_ALIGN_MISALIGN_TRAP_EN defined:
  - Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠0) issue no memory request.
  - Go IDLE→RESP with misalign=1 and resp_rdata=0.
- Undefined:
  - misalign is tied to 0.
  - Low address bits are forced aligned: half clears addr[0], word clears addr[1:0].
  - The access proceeds normally.

## Test plan
- Load byte, addr 0x103, mem word 0x80FF_1234, signed → resp_rdata 0xFFFF_FF80; unsigned → 0x0000_0080; mem_addr 0x40.
- Store half 0xBEEF to addr 0x22, mem holds 0x1122_3344 → read then write of 0xBEEF_3344 to word 0x8; resp_valid 3 cycles after accept with zero-wait ack.
- Store word 0xDEADBEEF to addr 0x10 with mem_ack delayed 3 cycles → single write, mem_req held 4 cycles, stall high throughout, resp_rdata 0.
- Load word at addr 0x06: with MEM_ALIGN_MISALIGN_TRAP_EN → misalign=1, resp_valid next cycle, mem_req never high; without → reads word 0x1 normally.
- Assert rst while in WR with mem_req high → mem_req, resp_valid and stall 0 immediately, req_ready 1. A late mem_ack produces no resp_valid, and the next load completes correctly.
